// File: rtl/pwm_ramp_sequencer_if.sv
// Command channel into pwm_ramp_sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready are
// both high. The master holds cmd_op/cmd_speed stable while cmd_valid is high and the
// command has not yet transferred. cmd_ready never depends combinationally on cmd_valid.
interface pwm_ramp_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_speed;

  modport master (output cmd_valid, output cmd_op, output cmd_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Command sequencer for one locked-antiphase pwm8 channel. It ramps a signed speed
// toward a commanded target once per RAMP_DIV PWM periods, and it always arms and
// disarms through neutral duty (8'h80). estop forces dynamic brake.
module pwm_ramp_sequencer #(
  parameter int RAMP_STEP = 4,
  parameter int RAMP_DIV  = 1,
  parameter int ARM_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cycle_tick,
  pwm_ramp_sequencer_if.slave cmd,
  input  logic                dir_invert_in,
  input  logic                estop,
  output logic                pwmldce,
  output logic [7:0]          wrtdata,
  output logic                enablepwm,
  output logic                run,
  output logic                invertpwm,
  output logic [7:0]          speed_cur,
  output logic                at_target,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    RUN      = 3'd2,
    STOPPING = 3'd3,
    BRAKE    = 3'd4
  } state_t;

  localparam logic [1:0]        OP_SET   = 2'b00;
  localparam logic [1:0]        OP_STOP  = 2'b01;
  localparam logic [1:0]        OP_BRAKE = 2'b10;
  localparam logic signed [7:0] STEP8    = 8'(RAMP_STEP);
  localparam logic signed [8:0] STEP9    = 9'(RAMP_STEP);
  localparam logic [7:0]        DIV_LAST = 8'(RAMP_DIV - 1);
  localparam logic [7:0]        ARM_LAST = 8'(ARM_TICKS - 1);
  localparam logic [7:0]        NEUTRAL  = 8'h80;

  // Offset-binary duty: signed speed plus 8'h80.
  function automatic logic [7:0] duty_of(input logic signed [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

  // One ramp step toward tgt; lands exactly on tgt when within one step.
  function automatic logic signed [7:0] ramp_toward(input logic signed [7:0] cur,
                                                   input logic signed [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({tgt[7], tgt}) - $signed({cur[7], cur});
    if (diff > STEP9)  return cur + STEP8;
    if (diff < -STEP9) return cur - STEP8;
    return tgt;
  endfunction

  state_t            state_q, state_d;
  logic signed [7:0] speed_q, speed_d, target_q, target_d, new_tgt;
  logic [7:0]        wrt_q, wrt_d, div_q, div_d, arm_q, arm_d;
  logic              ldce_q, ldce_d, en_q, en_d, run_q, run_d, inv_q, inv_d;
  logic              ready_q, ready_d, at_q, at_d;
  logic              accept, is_set, is_stop, is_brake, go_brake;

  // Nothing transfers while estop is high, even in the cycle before cmd_ready drops.
  assign accept   = cmd.cmd_valid && ready_q && !estop;
  assign is_set   = accept && (cmd.cmd_op == OP_SET);
  assign is_stop  = accept && (cmd.cmd_op == OP_STOP);
  assign is_brake = accept && (cmd.cmd_op == OP_BRAKE);
  // -128 has no positive mirror, so it is clamped to keep duty 8'h00 unreachable.
  assign new_tgt  = (cmd.cmd_speed == 8'h80) ? 8'sh81 : $signed(cmd.cmd_speed);

  // Next-state and next-output logic; every register has a registered output.
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;
    wrt_d    = wrt_q;
    div_d    = div_q;
    arm_d    = arm_q;
    ldce_d   = 1'b0;
    en_d     = en_q;
    run_d    = run_q;
    inv_d    = inv_q;
    go_brake = 1'b0;
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        run_d = 1'b1;
        inv_d = dir_invert_in;
        if (is_set) begin
          target_d = new_tgt;
          state_d  = ARM;
          arm_d    = '0;
          ldce_d   = 1'b1;
          wrt_d    = NEUTRAL;
        end else if (is_brake) begin
          go_brake = 1'b1;
        end
      end
      ARM: begin
        // pwm8 only picks up new duty at period start, so wait whole periods at neutral.
        if (cycle_tick) begin
          if (arm_q == ARM_LAST) begin
            state_d = RUN;
            en_d    = 1'b1;
            div_d   = '0;
          end else begin
            arm_d = arm_q + 8'd1;
          end
        end
      end
      RUN, STOPPING: begin
        en_d  = 1'b1;
        run_d = 1'b1;
        if (is_set) begin
          target_d = new_tgt;
          state_d  = RUN;
        end else if (is_stop) begin
          target_d = '0;
          state_d  = STOPPING;
        end else if (is_brake) begin
          go_brake = 1'b1;
        end
        if (cycle_tick) begin
          if (state_q == STOPPING && state_d == STOPPING && speed_q == 8'sd0) begin
            // Already at neutral for a full period: safe to drop the enable.
            state_d = IDLE;
            en_d    = 1'b0;
          end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            speed_d = ramp_toward(speed_q, target_d);
            if (speed_d != speed_q) begin
              ldce_d = 1'b1;
              wrt_d  = duty_of(speed_d);
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      BRAKE: begin
        en_d  = 1'b0;
        run_d = 1'b0;
        if (is_set) begin
          target_d = new_tgt;
          state_d  = ARM;
          arm_d    = '0;
          run_d    = 1'b1;
          ldce_d   = 1'b1;
          wrt_d    = NEUTRAL;
        end else if (is_stop) begin
          state_d = IDLE;
          run_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (estop || go_brake) begin
      state_d  = BRAKE;
      en_d     = 1'b0;
      run_d    = 1'b0;
      speed_d  = '0;
      target_d = '0;
      div_d    = '0;
      arm_d    = '0;
      ldce_d   = (state_q != BRAKE);
      if (state_q != BRAKE) wrt_d = NEUTRAL;
    end
  end

  always_comb begin
    at_d    = (state_d == RUN) && (speed_d == target_d);
    ready_d = !estop && (state_d != ARM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      speed_q  <= '0;
      target_q <= '0;
      wrt_q    <= NEUTRAL;
      div_q    <= '0;
      arm_q    <= '0;
      ldce_q   <= 1'b0;
      en_q     <= 1'b0;
      run_q    <= 1'b1;
      inv_q    <= 1'b0;
      ready_q  <= 1'b0;
      at_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      wrt_q    <= wrt_d;
      div_q    <= div_d;
      arm_q    <= arm_d;
      ldce_q   <= ldce_d;
      en_q     <= en_d;
      run_q    <= run_d;
      inv_q    <= inv_d;
      ready_q  <= ready_d;
      at_q     <= at_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign pwmldce       = ldce_q;
  assign wrtdata       = wrt_q;
  assign enablepwm     = en_q;
  assign run           = run_q;
  assign invertpwm     = inv_q;
  assign speed_cur     = speed_q;
  assign at_target     = at_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: u1 uses STEP=4 DIV=1, u2 uses STEP=4 DIV=3.
module tb_pwm_ramp_sequencer;

  localparam logic [1:0] OP_SET = 2'b00, OP_STOP = 2'b01;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic tick1 = 1'b0, tick2 = 1'b0, estop = 1'b0, estop2 = 1'b0;
  logic dir_inv = 1'b0, dir_inv2 = 1'b0;
  logic       ldce1, en1, run1, inv1, at1, ldce2, en2, run2, inv2, at2;
  logic [7:0] wrt1, spd1, wrt2, spd2;
  logic [2:0] st1, st2;

  pwm_ramp_sequencer_if c1 ();
  pwm_ramp_sequencer_if c2 ();

  pwm_ramp_sequencer #(.RAMP_STEP(4), .RAMP_DIV(1), .ARM_TICKS(2)) u1 (
    .clk(clk), .reset(reset), .cycle_tick(tick1), .cmd(c1.slave),
    .dir_invert_in(dir_inv), .estop(estop), .pwmldce(ldce1), .wrtdata(wrt1),
    .enablepwm(en1), .run(run1), .invertpwm(inv1), .speed_cur(spd1),
    .at_target(at1), .state(st1));

  pwm_ramp_sequencer #(.RAMP_STEP(4), .RAMP_DIV(3), .ARM_TICKS(2)) u2 (
    .clk(clk), .reset(reset), .cycle_tick(tick2), .cmd(c2.slave),
    .dir_invert_in(dir_inv2), .estop(estop2), .pwmldce(ldce2), .wrtdata(wrt2),
    .enablepwm(en2), .run(run2), .invertpwm(inv2), .speed_cur(spd2),
    .at_target(at2), .state(st2));

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ldce_q[$];
  logic [7:0] ldce2_q[$];
  logic [7:0] exp_q[$];
  bit         saw_zero2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every load strobe is captured, so a strobe held two cycles shows up as an extra entry.
  always @(posedge clk) begin
    #1;
    if (ldce1) ldce_q.push_back(wrt1);
    if (ldce2) begin
      ldce2_q.push_back(wrt2);
      if (wrt2 == 8'h00) saw_zero2 = 1'b1;
    end
  end

  task automatic check_ldce(input string tag, input bit unit2);
    logic [7:0] got_q[$];
    got_q = unit2 ? ldce2_q : ldce_q;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    if (unit2) ldce2_q.delete(); else ldce_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic tick(input bit unit2);
    @(negedge clk);
    if (unit2) tick2 = 1'b1; else tick1 = 1'b1;
    @(negedge clk);
    tick1 = 1'b0;
    tick2 = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] spd);
    int budget;
    c1.cmd_valid = 1'b1;
    c1.cmd_op    = op;
    c1.cmd_speed = spd;
    budget = 20;
    while (!c1.cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("send_timeout", 0, 1);
    @(negedge clk);
    c1.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    c1.cmd_valid = 1'b0; c1.cmd_op = 2'b00; c1.cmd_speed = 8'h00;
    c2.cmd_valid = 1'b0; c2.cmd_op = 2'b00; c2.cmd_speed = 8'h00;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_ready", c1.cmd_ready, 0);
    chk("rst_state", st1, 0);
    chk("rst_wrt", wrt1, 8'h80);
    chk("rst_en", en1, 0);
    chk("rst_run", run1, 1);
    chk("rst_inv", inv1, 0);
    chk("rst_spd", spd1, 0);
    chk("rst_at", at1, 0);
    chk("rst_ldce", ldce1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", c1.cmd_ready, 1);
    dir_inv = 1'b1;
    @(negedge clk);
    chk("idle_inv_hi", inv1, 1);
    dir_inv = 1'b0;
    @(negedge clk);
    chk("idle_inv_lo", inv1, 0);

    // 1: arm through neutral, ramp to +20
    send(OP_SET, 8'd20);
    chk("t1_arm_state", st1, 1);
    chk("t1_arm_en", en1, 0);
    chk("t1_arm_ready", c1.cmd_ready, 0);
    tick(0);
    chk("t1_tick1_state", st1, 1);
    chk("t1_tick1_en", en1, 0);
    tick(0);
    chk("t1_run_state", st1, 2);
    chk("t1_run_en", en1, 1);
    chk("t1_run_at", at1, 0);
    repeat (5) tick(0);
    chk("t1_spd", spd1, 8'h14);
    chk("t1_wrt", wrt1, 8'h94);
    chk("t1_at", at1, 1);
    tick(0);
    exp_q = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94};
    check_ldce("t1_ldce", 0);

    // 2: +10 then across zero to -10
    send(OP_SET, 8'd10);
    repeat (3) tick(0);
    chk("t2_spd10", spd1, 8'h0A);
    chk("t2_at10", at1, 1);
    send(OP_SET, 8'hF6);
    chk("t2_retarget_at", at1, 0);
    repeat (2) tick(0);
    chk("t2_spd2", spd1, 8'h02);
    chk("t2_mid_en", en1, 1);
    chk("t2_mid_run", run1, 1);
    repeat (3) tick(0);
    chk("t2_spdm10", spd1, 8'hF6);
    chk("t2_wrt", wrt1, 8'h76);
    chk("t2_en", en1, 1);
    chk("t2_run", run1, 1);
    chk("t2_at", at1, 1);
    exp_q = '{8'h90, 8'h8C, 8'h8A, 8'h86, 8'h82, 8'h7E, 8'h7A, 8'h76};
    check_ldce("t2_ldce", 0);

    // 3: STOP from +6
    send(OP_SET, 8'd6);
    repeat (4) tick(0);
    chk("t3_spd6", spd1, 8'h06);
    ldce_q.delete();
    send(OP_STOP, 8'h00);
    chk("t3_stopping", st1, 3);
    chk("t3_stop_at", at1, 0);
    repeat (2) tick(0);
    chk("t3_spd0", spd1, 0);
    chk("t3_wrt80", wrt1, 8'h80);
    chk("t3_still_stopping", st1, 3);
    chk("t3_still_en", en1, 1);
    tick(0);
    chk("t3_idle", st1, 0);
    chk("t3_en_off", en1, 0);
    chk("t3_run", run1, 1);
    tick(0);
    exp_q = '{8'h82, 8'h80};
    check_ldce("t3_ldce", 0);

    // 4: estop mid-ramp
    send(OP_SET, 8'd40);
    repeat (4) tick(0);
    chk("t4_spd8", spd1, 8'h08);
    estop = 1'b1;
    @(negedge clk);
    chk("t4_run", run1, 0);
    chk("t4_en", en1, 0);
    chk("t4_state", st1, 4);
    chk("t4_ready", c1.cmd_ready, 0);
    chk("t4_spd", spd1, 0);
    @(negedge clk);
    chk("t4_hold_state", st1, 4);
    estop = 1'b0;
    @(negedge clk);
    chk("t4_rel_ready", c1.cmd_ready, 1);
    chk("t4_rel_state", st1, 4);
    chk("t4_rel_run", run1, 0);
    exp_q = '{8'h80, 8'h84, 8'h88, 8'h80};
    check_ldce("t4_ldce", 0);

    // 6: re-arm from brake, command held during ARM, invert ignored in RUN
    send(OP_SET, 8'd8);
    chk("t6_arm_state", st1, 1);
    chk("t6_arm_run", run1, 1);
    chk("t6_arm_ready", c1.cmd_ready, 0);
    c1.cmd_valid = 1'b1;
    c1.cmd_op    = OP_SET;
    c1.cmd_speed = 8'd12;
    tick(0);
    chk("t6_hold_ready", c1.cmd_ready, 0);
    chk("t6_hold_state", st1, 1);
    tick(0);
    chk("t6_run_state", st1, 2);
    chk("t6_run_ready", c1.cmd_ready, 1);
    chk("t6_run_en", en1, 1);
    @(negedge clk);
    c1.cmd_valid = 1'b0;
    dir_inv = 1'b1;
    repeat (3) tick(0);
    chk("t6_spd12", spd1, 8'h0C);
    chk("t6_at", at1, 1);
    chk("t6_inv", inv1, 0);
    dir_inv = 1'b0;
    exp_q = '{8'h80, 8'h84, 8'h88, 8'h8C};
    check_ldce("t6_ldce", 0);

    // 5: -128 clamped, ramp every 3rd tick on u2
    chk("t5_ready", c2.cmd_ready, 1);
    c2.cmd_valid = 1'b1;
    c2.cmd_op    = OP_SET;
    c2.cmd_speed = 8'h80;
    @(negedge clk);
    c2.cmd_valid = 1'b0;
    chk("t5_arm", st2, 1);
    repeat (2) tick(1);
    chk("t5_run", st2, 2);
    repeat (2) tick(1);
    chk("t5_no_step_spd", spd2, 0);
    chk("t5_no_step_ldce", ldce2_q.size(), 1);
    tick(1);
    chk("t5_first_spd", spd2, 8'hFC);
    chk("t5_first_wrt", wrt2, 8'h7C);
    repeat (93) tick(1);
    chk("t5_final_wrt", wrt2, 8'h01);
    chk("t5_final_spd", spd2, 8'h81);
    chk("t5_at", at2, 1);
    repeat (3) tick(1);
    chk("t5_never_00", saw_zero2, 0);
    exp_q.push_back(8'h80);
    for (int k = 1; k <= 31; k++) exp_q.push_back(8'(128 - 4 * k));
    exp_q.push_back(8'h01);
    check_ldce("t5_ldce", 1);

    // reset mid-ramp on u1
    send(OP_SET, 8'd40);
    tick(0);
    chk("rr_spd16", spd1, 8'h10);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_state", st1, 0);
    chk("rr_spd", spd1, 0);
    chk("rr_wrt", wrt1, 8'h80);
    chk("rr_en", en1, 0);
    chk("rr_run", run1, 1);
    chk("rr_ready", c1.cmd_ready, 0);
    chk("rr_at", at1, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rr_ready_after", c1.cmd_ready, 1);
    exp_q = '{8'h90};
    check_ldce("rr_ldce", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
